// File: rtl/account_session_ctrl.sv
// account_session_ctrl
//   Per-card ATM session controller. It looks up the account, checks the PIN, keeps a
//   retry count and lock flag for every card across sessions, ends idle sessions, and
//   writes the post-transaction balance back. Accounts are loaded over a provisioning port.
//
//   Ports
//     clk, rst                    clock (rising edge), asynchronous active-low reset
//     card_in, card_number        card insertion pulse and card id
//     psw_valid, password_input   PIN entry pulse and PIN value
//     op_done, updated_balance    transaction complete pulse and new balance
//     card_out                    card ejected / end of session request
//     prog_en, prog_card,
//     prog_psw, prog_bal          account provisioning (accepted only in IDLE)
//     balance, session_active     balance of the logged-in account; high while in AUTH
//     auth_ok, wrong_psw,
//     card_locked, invalid_card,
//     timeout                     single-cycle event pulses
//     tries_left                  attempts remaining for the latched card
//
//   state  | meaning
//   IDLE   | no card; provisioning and card insertion accepted
//   VERIFY | card latched, waiting for PIN
//   AUTH   | PIN accepted, transactions allowed
module account_session_ctrl #(
  parameter int CARD_W      = 6,
  parameter int PSW_W       = 16,
  parameter int BAL_W       = 20,
  parameter int USERS       = 10,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           card_in,
  input  logic [CARD_W-1:0]              card_number,
  input  logic                           psw_valid,
  input  logic [PSW_W-1:0]               password_input,
  input  logic                           op_done,
  input  logic [BAL_W-1:0]               updated_balance,
  input  logic                           card_out,
  input  logic                           prog_en,
  input  logic [CARD_W-1:0]              prog_card,
  input  logic [PSW_W-1:0]               prog_psw,
  input  logic [BAL_W-1:0]               prog_bal,
  output logic [BAL_W-1:0]               balance,
  output logic                           session_active,
  output logic                           auth_ok,
  output logic                           wrong_psw,
  output logic                           card_locked,
  output logic                           invalid_card,
  output logic                           timeout,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries_left
);

  localparam int TW    = $clog2(MAX_TRIES + 1);
  localparam int IDX_W = (USERS > 1) ? $clog2(USERS) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYC);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_AUTH   = 2'd2;

  localparam logic [CARD_W-1:0] USERS_C  = CARD_W'(USERS);
  localparam logic [TW-1:0]     MAX_C    = TW'(MAX_TRIES);
  localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);

  logic [1:0]       state, state_nxt;
  logic [IDX_W-1:0] card_reg, card_nxt;
  logic [TMR_W-1:0] timer_cnt, timer_nxt;

  logic [USERS-1:0] lock_flag;
  logic [TW-1:0]    tries_cnt [USERS];
  logic [PSW_W-1:0] psw_mem   [USERS];
  logic [BAL_W-1:0] bal_mem   [USERS];

  logic [IDX_W-1:0] card_idx, prog_idx;
  logic [TW-1:0]    tries_inc, tries_val, tries_sel;
  logic             prog_wr, bal_wr, tries_wr, lock_set;
  logic [BAL_W-1:0] bal_nxt;
  logic             auth_nxt, wrong_nxt, locked_nxt, invalid_nxt, tmo_nxt;

  assign card_idx  = card_number[IDX_W-1:0];
  assign prog_idx  = prog_card[IDX_W-1:0];
  assign tries_inc = tries_cnt[card_reg] + TW'(1);

  always_comb begin
    state_nxt   = state;
    card_nxt    = card_reg;
    timer_nxt   = timer_cnt;
    bal_nxt     = balance;
    auth_nxt    = 1'b0;
    wrong_nxt   = 1'b0;
    locked_nxt  = 1'b0;
    invalid_nxt = 1'b0;
    tmo_nxt     = 1'b0;
    prog_wr     = 1'b0;
    bal_wr      = 1'b0;
    tries_wr    = 1'b0;
    tries_val   = '0;
    lock_set    = 1'b0;
    case (state)
      ST_IDLE: begin
        // An out-of-range provisioning write is dropped as if absent.
        if (prog_en && (prog_card < USERS_C)) begin
          prog_wr = 1'b1;
        end else if (card_in) begin
          if (card_number >= USERS_C) begin
            invalid_nxt = 1'b1;
          end else if (lock_flag[card_idx]) begin
            locked_nxt = 1'b1;
          end else begin
            card_nxt  = card_idx;
            timer_nxt = TMR_LOAD;
            state_nxt = ST_VERIFY;
          end
        end
      end
      ST_VERIFY: begin
        if (card_out) begin
          state_nxt = ST_IDLE;
        end else if (psw_valid) begin
          timer_nxt = TMR_LOAD;
          tries_wr  = 1'b1;
          if (password_input == psw_mem[card_reg]) begin
            auth_nxt  = 1'b1;
            bal_nxt   = bal_mem[card_reg];
            tries_val = '0;
            state_nxt = ST_AUTH;
          end else begin
            wrong_nxt = 1'b1;
            tries_val = tries_inc;
            if (tries_inc == MAX_C) begin
              lock_set   = 1'b1;
              locked_nxt = 1'b1;
              state_nxt  = ST_IDLE;
            end
          end
        end else if (timer_cnt == '0) begin
          tmo_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          timer_nxt = timer_cnt - TMR_W'(1);
        end
      end
      ST_AUTH: begin
        // A write-back arriving with card_out still lands before the session closes.
        if (op_done) begin
          bal_wr    = 1'b1;
          bal_nxt   = updated_balance;
          timer_nxt = TMR_LOAD;
        end
        if (card_out) begin
          state_nxt = ST_IDLE;
        end else if (!op_done) begin
          if (timer_cnt == '0) begin
            tmo_nxt   = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            timer_nxt = timer_cnt - TMR_W'(1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (state_nxt != ST_AUTH) bal_nxt = '0;
  end

  assign tries_sel = tries_wr ? tries_val : tries_cnt[card_nxt];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      card_reg       <= '0;
      timer_cnt      <= '0;
      balance        <= '0;
      session_active <= 1'b0;
      auth_ok        <= 1'b0;
      wrong_psw      <= 1'b0;
      card_locked    <= 1'b0;
      invalid_card   <= 1'b0;
      timeout        <= 1'b0;
      tries_left     <= '0;
    end else begin
      state          <= state_nxt;
      card_reg       <= card_nxt;
      timer_cnt      <= timer_nxt;
      balance        <= bal_nxt;
      session_active <= (state_nxt == ST_AUTH);
      auth_ok        <= auth_nxt;
      wrong_psw      <= wrong_nxt;
      card_locked    <= locked_nxt;
      invalid_card   <= invalid_nxt;
      timeout        <= tmo_nxt;
      tries_left     <= (state_nxt == ST_IDLE) ? '0 : (MAX_C - tries_sel);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_flag <= '0;
      for (int i = 0; i < USERS; i++) tries_cnt[i] <= '0;
    end else begin
      if (prog_wr) begin
        lock_flag[prog_idx] <= 1'b0;
        tries_cnt[prog_idx] <= '0;
      end
      if (tries_wr) tries_cnt[card_reg] <= tries_val;
      if (lock_set) lock_flag[card_reg] <= 1'b1;
    end
  end

  // Account contents survive reset; only provisioning and write-back change them.
  always_ff @(posedge clk) begin
    if (prog_wr) begin
      psw_mem[prog_idx] <= prog_psw;
      bal_mem[prog_idx] <= prog_bal;
    end else if (bal_wr) begin
      bal_mem[card_reg] <= updated_balance;
    end
  end

endmodule

// File: tb/tb_account_session_ctrl.sv
// tb_account_session_ctrl
//   Directed vectors with hand-computed expectations for account_session_ctrl
//   (default parameters: USERS=10, MAX_TRIES=3, TIMEOUT_CYC=1000).
module tb_account_session_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        card_in = 1'b0;
  logic [5:0]  card_number = '0;
  logic        psw_valid = 1'b0;
  logic [15:0] password_input = '0;
  logic        op_done = 1'b0;
  logic [19:0] updated_balance = '0;
  logic        card_out = 1'b0;
  logic        prog_en = 1'b0;
  logic [5:0]  prog_card = '0;
  logic [15:0] prog_psw = '0;
  logic [19:0] prog_bal = '0;
  logic [19:0] balance;
  logic        session_active, auth_ok, wrong_psw, card_locked, invalid_card, timeout;
  logic [1:0]  tries_left;

  int n_checks = 0;
  int n_pass   = 0;

  account_session_ctrl dut (
    .clk(clk), .rst(rst),
    .card_in(card_in), .card_number(card_number),
    .psw_valid(psw_valid), .password_input(password_input),
    .op_done(op_done), .updated_balance(updated_balance),
    .card_out(card_out),
    .prog_en(prog_en), .prog_card(prog_card), .prog_psw(prog_psw), .prog_bal(prog_bal),
    .balance(balance), .session_active(session_active),
    .auth_ok(auth_ok), .wrong_psw(wrong_psw), .card_locked(card_locked),
    .invalid_card(invalid_card), .timeout(timeout), .tries_left(tries_left)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_prog(input logic [5:0] c, input logic [15:0] p, input logic [19:0] b);
    prog_card = c; prog_psw = p; prog_bal = b; prog_en = 1'b1;
    tick();
    prog_en = 1'b0;
  endtask

  task automatic do_card(input logic [5:0] c);
    card_number = c; card_in = 1'b1;
    tick();
    card_in = 1'b0;
  endtask

  task automatic do_psw(input logic [15:0] p);
    password_input = p; psw_valid = 1'b1;
    tick();
    psw_valid = 1'b0;
  endtask

  task automatic do_out();
    card_out = 1'b1;
    tick();
    card_out = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    check("rst_balance", balance, 0);
    check("rst_active", session_active, 0);
    check("rst_pulses", {auth_ok, wrong_psw, card_locked, invalid_card, timeout}, 0);
    check("rst_tries", tries_left, 0);
    rst = 1'b1;
    tick();

    do_prog(6'd2, 16'h1234, 20'd500);
    do_prog(6'd5, 16'hAAAA, 20'd77);
    do_prog(6'd3, 16'h0303, 20'd1000);

    // Login card 2
    do_card(6'd2);
    check("c2_verify_tries", tries_left, 3);
    check("c2_verify_inactive", session_active, 0);
    do_psw(16'h1234);
    check("c2_auth_ok", auth_ok, 1);
    check("c2_balance", balance, 500);
    check("c2_active", session_active, 1);
    tick();
    check("c2_auth_ok_pulse", auth_ok, 0);

    // Write-back together with card_out
    updated_balance = 20'd320; op_done = 1'b1; card_out = 1'b1;
    tick();
    op_done = 1'b0; card_out = 1'b0;
    check("wb_out_inactive", session_active, 0);
    check("wb_out_balance", balance, 0);
    do_card(6'd2);
    do_psw(16'h1234);
    check("c2_relogin_balance", balance, 320);
    do_out();

    // Three wrong PINs on card 5
    do_card(6'd5);
    do_psw(16'h0000);
    check("c5_wrong1", {wrong_psw, card_locked}, 2'b10);
    check("c5_tries1", tries_left, 2);
    do_psw(16'h0001);
    check("c5_wrong2", {wrong_psw, card_locked}, 2'b10);
    check("c5_tries2", tries_left, 1);
    do_psw(16'h0002);
    check("c5_wrong3_lock", {wrong_psw, card_locked}, 2'b11);
    check("c5_lock_idle", {session_active, tries_left}, 0);
    tick();
    do_card(6'd5);
    check("c5_locked_insert", {wrong_psw, card_locked, invalid_card}, 3'b010);
    check("c5_locked_tries", tries_left, 0);
    do_psw(16'hAAAA);
    check("c5_locked_no_auth", auth_ok, 0);

    // Out-of-range cards
    do_card(6'd12);
    check("inv12_pulse", invalid_card, 1);
    check("inv12_tries", tries_left, 0);
    do_psw(16'h1234);
    check("inv12_stays_idle", auth_ok, 0);
    do_card(6'd10);
    check("inv10_pulse", invalid_card, 1);

    // Reprovisioning clears the lock
    do_prog(6'd5, 16'hBBBB, 20'd55);
    do_card(6'd5);
    check("c5_reprog_unlocked", card_locked, 0);
    check("c5_reprog_tries", tries_left, 3);
    do_psw(16'hBBBB);
    check("c5_reprog_balance", balance, 55);
    do_out();

    // Idle timeout, with op_done restarting the idle count
    do_card(6'd3);
    do_psw(16'h0303);
    check("c3_balance", balance, 1000);
    repeat (600) tick();
    updated_balance = 20'd900; op_done = 1'b1;
    tick();
    op_done = 1'b0;
    check("c3_wb_balance", balance, 900);
    repeat (999) tick();
    check("tmo_not_yet", {session_active, timeout}, 2'b10);
    tick();
    check("tmo_pulse", timeout, 1);
    check("tmo_balance", balance, 0);
    check("tmo_inactive", session_active, 0);
    tick();
    check("tmo_pulse_end", timeout, 0);

    // Two wrong PINs survive re-insertion; correct PIN restores tries
    do_card(6'd3);
    do_psw(16'h1111);
    do_psw(16'h2222);
    check("c3_tries_after2", tries_left, 1);
    do_out();
    check("c3_out_tries", tries_left, 0);
    do_card(6'd3);
    check("c3_reinsert_tries", tries_left, 1);
    do_psw(16'h0303);
    check("c3_stored_balance", balance, 900);
    check("c3_tries_restored", tries_left, 3);

    // Asynchronous reset in AUTH
    rst = 1'b0;
    #2;
    check("arst_active", session_active, 0);
    check("arst_balance", balance, 0);
    check("arst_tries", tries_left, 0);
    tick();
    rst = 1'b1;
    tick();
    do_card(6'd3);
    check("post_rst_tries", tries_left, 3);
    do_psw(16'h0303);
    check("post_rst_balance", balance, 900);
    do_out();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
